// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state, requester ids and read-return tag for ram_port_arb
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  localparam int REQ_CTRL = 0;
  localparam int REQ_HOST = 1;
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage tag shift register (clk, rst clear, din in, dout after DEPTH edges)
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t din,
  output tag_t dout
);
  tag_t [DEPTH-1:0] sr;
  always_ff @(posedge clk) begin
    sr[0] <= rst ? '0 : din;
    for (int i = 1; i < DEPTH; i++) sr[i] <= rst ? '0 : sr[i-1];
  end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin/burst-lock arbiter of one RAM port (req/we/lock/addr/wdata in, gnt/rvalid/rdata out, ram_* to RAM)
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [1:0]            lock,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  state_t state, state_nxt;
  logic prio, prio_nxt;
  tag_t tag_in, tag_out;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
    prio  <= rst ? 1'b0 : prio_nxt;
  end
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      IDLE: begin
        prio_nxt  = |gnt ? gnt[REQ_CTRL] : prio;
        state_nxt = (gnt[REQ_CTRL] & lock[REQ_CTRL]) ? LOCK0 :
                    (gnt[REQ_HOST] & lock[REQ_HOST]) ? LOCK1 : IDLE;
      end
      LOCK0: begin
        state_nxt = (req[REQ_CTRL] & lock[REQ_CTRL]) ? LOCK0 : IDLE;
        prio_nxt  = (req[REQ_CTRL] & lock[REQ_CTRL]) ? prio : 1'b1;
      end
      LOCK1: begin
        state_nxt = (req[REQ_HOST] & lock[REQ_HOST]) ? LOCK1 : IDLE;
        prio_nxt  = (req[REQ_HOST] & lock[REQ_HOST]) ? prio : 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    gnt      = state == LOCK0 ? {1'b0, req[REQ_CTRL]} :
               state == LOCK1 ? {req[REQ_HOST], 1'b0} :
               req == 2'b11   ? (prio ? 2'b10 : 2'b01) : req;
    ram_addr = gnt[REQ_HOST] ? addr1 : gnt[REQ_CTRL] ? addr0 : '0;
    ram_din  = gnt[REQ_HOST] ? wdata1 : gnt[REQ_CTRL] ? wdata0 : '0;
    ram_we   = ~rst & |(gnt & we);
    tag_in   = '{valid: |(gnt & ~we), id: gnt[REQ_HOST]};
    rvalid   = (tag_out.valid & ~rst) ? (tag_out.id ? 2'b10 : 2'b01) : 2'b00;
    rdata    = |rvalid ? ram_dout : '0;
  end
  rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_pipe (
    .clk (clk),
    .rst (rst),
    .din (tag_in),
    .dout(tag_out)
  );
endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: scoreboard bench driving latency-1 and latency-3 arbiters with shared stimulus
module tb_ram_port_arb;
  typedef struct {
    logic [1:0]  rv;
    logic [63:0] d;
    int          due;
  } ret_t;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, we = 0, lock = 0;
  logic [11:0] addr0 = 0, addr1 = 0;
  logic [63:0] wdata0 = 0, wdata1 = 0;
  logic [1:0] gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [63:0] rdata_a, rdata_b, din_a, din_b, dout_a, dout_b, p1, p2;
  logic [11:0] ra_a, ra_b;
  logic we_a, we_b;
  logic [63:0] mem_a [4096];
  logic [63:0] mem_b [4096];
  ret_t q [2][$];
  ret_t me;
  logic [1:0] mv;
  logic [63:0] md;
  int cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ram_port_arb #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .ram_addr(ra_a), .ram_din(din_a), .ram_we(we_a), .ram_dout(dout_a)
  );
  ram_port_arb #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .ram_addr(ra_b), .ram_din(din_b), .ram_we(we_b), .ram_dout(dout_b)
  );
  always @(posedge clk) begin
    if (we_a) mem_a[ra_a] <= din_a;
    dout_a <= mem_a[ra_a];
    if (we_b) mem_b[ra_b] <= din_b;
    p1 <= mem_b[ra_b];
    p2 <= p1;
    dout_b <= p2;
  end
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mv = k ? rvalid_b : rvalid_a;
      md = k ? rdata_b : rdata_a;
      if (mv != 0) begin
        if (q[k].size() == 0) chk($sformatf("ret%0d_unexpected", k), {62'd0, mv}, 64'd0);
        else begin
          me = q[k].pop_front();
          chk($sformatf("ret%0d_rvalid", k), {62'd0, mv}, {62'd0, me.rv});
          chk($sformatf("ret%0d_rdata", k), md, me.d);
          chk($sformatf("ret%0d_cycle", k), 64'(cyc), 64'(me.due));
        end
      end else begin
        chk($sformatf("ret%0d_rdata_idle", k), md, 64'd0);
        if (q[k].size() != 0 && q[k][0].due <= cyc) begin
          me = q[k].pop_front();
          chk($sformatf("ret%0d_missing", k), 64'd0, {62'd0, me.rv});
        end
      end
    end
  end
  task automatic step(input logic [1:0] r, l, w, input logic [11:0] a0, a1, input logic [63:0] d0,
                      input logic [1:0] eg, er, input logic [63:0] ed);
    req = r; lock = l; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = ~d0;
    @(negedge clk);
    chk("gnt_a", {62'd0, gnt_a}, {62'd0, eg});
    chk("gnt_b", {62'd0, gnt_b}, {62'd0, eg});
    chk("ram_we", {63'd0, we_a}, {63'd0, ~rst & |(eg & w)});
    chk("ram_addr", {52'd0, ra_a}, {52'd0, eg[1] ? a1 : eg[0] ? a0 : 12'd0});
    chk("ram_din", din_a, eg[1] ? ~d0 : eg[0] ? d0 : 64'd0);
    if (er != 0) begin
      q[0].push_back('{rv: er, d: ed, due: cyc + 1});
      q[1].push_back('{rv: er, d: ed, due: cyc + 3});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 0;
      mem_b[i] = 0;
    end
    mem_a[12'h010] = 64'hA; mem_b[12'h010] = 64'hA;
    mem_a[12'h011] = 64'hB; mem_b[12'h011] = 64'hB;
    mem_a[12'h012] = 64'hC; mem_b[12'h012] = 64'hC;
    for (int i = 0; i < 4; i++) begin
      mem_a[12'h020 + i] = 64'hF020 + 64'(i);
      mem_b[12'h020 + i] = 64'hF020 + 64'(i);
    end
    @(posedge clk); #1;
    step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 64'h0, 2'b00, 2'b00, 64'h0);
    step(2'b01, 2'b00, 2'b01, 12'h055, 12'h000, 64'h77, 2'b01, 2'b00, 64'h0);
    rst = 0;
    step(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 64'h0, 2'b01, 2'b01, 64'hA);
    step(2'b01, 2'b00, 2'b00, 12'h011, 12'h000, 64'h0, 2'b01, 2'b01, 64'hB);
    step(2'b10, 2'b00, 2'b00, 12'h000, 12'h012, 64'h0, 2'b10, 2'b10, 64'hC);
    repeat (2) begin
      step(2'b11, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b01, 2'b01, 64'hA);
      step(2'b11, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b10, 2'b10, 64'hB);
    end
    step(2'b01, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b01, 2'b01, 64'hA);
    repeat (3) step(2'b11, 2'b10, 2'b00, 12'h010, 12'h011, 64'h0, 2'b10, 2'b10, 64'hB);
    step(2'b11, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b10, 2'b10, 64'hB);
    step(2'b11, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b01, 2'b01, 64'hA);
    step(2'b01, 2'b01, 2'b00, 12'h010, 12'h011, 64'h0, 2'b01, 2'b01, 64'hA);
    step(2'b10, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b00, 2'b00, 64'h0);
    step(2'b11, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b10, 2'b10, 64'hB);
    step(2'b01, 2'b00, 2'b01, 12'h100, 12'h000, 64'hDEAD, 2'b01, 2'b00, 64'h0);
    step(2'b10, 2'b00, 2'b00, 12'h000, 12'h100, 64'h0, 2'b10, 2'b10, 64'hDEAD);
    step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 64'h0, 2'b00, 2'b00, 64'h0);
    repeat (3) step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 64'h0, 2'b00, 2'b00, 64'h0);
    step(2'b01, 2'b01, 2'b00, 12'h010, 12'h000, 64'h0, 2'b01, 2'b00, 64'h0);
    rst = 1;
    q[0].delete();
    q[1].delete();
    step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 64'h0, 2'b00, 2'b00, 64'h0);
    rst = 0;
    repeat (4) step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 64'h0, 2'b00, 2'b00, 64'h0);
    step(2'b11, 2'b00, 2'b00, 12'h010, 12'h011, 64'h0, 2'b01, 2'b01, 64'hA);
    step(2'b10, 2'b00, 2'b00, 12'h000, 12'h021, 64'h0, 2'b10, 2'b10, 64'hF021);
    step(2'b01, 2'b00, 2'b00, 12'h020, 12'h000, 64'h0, 2'b01, 2'b01, 64'hF020);
    step(2'b10, 2'b00, 2'b00, 12'h000, 12'h023, 64'h0, 2'b10, 2'b10, 64'hF023);
    step(2'b01, 2'b00, 2'b00, 12'h022, 12'h000, 64'h0, 2'b01, 2'b01, 64'hF022);
    step(2'b11, 2'b00, 2'b00, 12'h020, 12'h021, 64'h0, 2'b10, 2'b10, 64'hF021);
    step(2'b11, 2'b00, 2'b00, 12'h020, 12'h021, 64'h0, 2'b01, 2'b01, 64'hF020);
    repeat (5) step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 64'h0, 2'b00, 2'b00, 64'h0);
    chk("drain_a", 64'(q[0].size()), 64'd0);
    chk("drain_b", 64'(q[1].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_port_arb.md
# ram_port_arb

Two-requester arbiter for one port of a `dual_ram` instance. It shares the port between the instruction-driven `Control` datapath (requester 0) and a host/DMA load-unload engine (requester 1). Arbitration is round-robin with an optional burst lock, and read data returns to the granted requester after the fixed RAM read latency. It sits between the requesters and the RAM's `addr`/`din`/`we`/`dout` pins.

## Interface
- `ADDR_WIDTH`, 12, RAM word address width
- `DATA_WIDTH`, 64, RAM word width
- `RD_LATENCY`, 1, RAM read latency in cycles (1–3 supported)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  2  access request per requester; bit n = requester n
- `we`  in  2  per-requester write enable; qualified by `req[n]`
- `lock`  in  2  per-requester burst lock; qualified by `req[n]`
- `addr0`, `addr1`  in  ADDR_WIDTH each  per-requester address
- `wdata0`, `wdata1`  in  DATA_WIDTH each  per-requester write data
- `gnt`  out  2  one-hot-or-zero grant, combinational, same cycle as `req`
- `rvalid`  out  2  read-return strobe per requester
- `rdata`  out  DATA_WIDTH  shared read-return bus; valid only when a bit of `rvalid` is set
- `ram_addr`  out  ADDR_WIDTH  to RAM port address
- `ram_din`  out  DATA_WIDTH  to RAM port write data
- `ram_we`  out  1  to RAM port write enable
- `ram_dout`  in  DATA_WIDTH  from RAM port read data

## Operation
- **States:** `IDLE`, `LOCK0`, `LOCK1`. The round-robin pointer `prio` is 1 bit; 0 means requester 0 wins a tie.
- **IDLE:**
  - If exactly one `req` bit is set, grant that requester.
  - If both are set, grant `prio`.
  - After any grant, `prio` becomes the requester that was *not* granted.
- **LOCK entry:** a requester granted in IDLE with its `lock` high moves the state to `LOCKn` at the next edge.
- **LOCKn:**
  - Only requester n can be granted. The other requester's `req` is ignored and it waits; no error is raised.
  - When `req[n]` is high, grant n. Otherwise `gnt = 0`.
- **LOCK exit:**
  - In a cycle of `LOCKn` where `req[n]` or `lock[n]` is low, the state returns to IDLE at the next edge.
  - That cycle's `req[n]`, if high, is still granted.
  - `prio` is set to the other requester on exit, so the waiting requester wins the first IDLE tie.
- **RAM muxing:**
  - With no grant: `ram_we = 0`, `ram_addr = 0`, `ram_din = 0`.
  - Otherwise `ram_addr`, `ram_din` and `ram_we` are taken from the granted requester.
  - `ram_we` equals the granted requester's `we`.
- **Read return:**
  - A granted read (`we = 0`) pushes tag {valid=1, id=n} into a `RD_LATENCY`-deep shift pipe. A cycle with no grant, or a granted write, pushes valid=0.
  - At the pipe output, `rvalid[id]` is asserted and `rdata = ram_dout`. Otherwise `rvalid = 0` and `rdata = 0`.
- **Writes** produce no response. A write granted in cycle T is visible to a read granted in cycle T+1.

## Timing
- **Reset:**
  - `state = IDLE`, `prio = 0`, tag pipe cleared.
  - Outputs: `gnt = 0` (when `req = 0`), `rvalid = 0`, `rdata = 0`, `ram_we = 0`, `ram_addr = 0`, `ram_din = 0`.
- **Grant:** zero-latency (combinational from `req`, `lock`, `state`, `prio`).
- **Throughput:** one access per cycle. Back-to-back grants are allowed without bubbles.
- **Read latency:** a read granted in cycle T gives `rvalid` in cycle T+`RD_LATENCY`. Returns stay in grant order.
- **Simultaneous events:**
  - A grant switching requesters in the same cycle as a return to the previous owner is legal. Return routing uses the stored tag, not the current grant.
- **Reset mid-operation:** reads still in the pipe are dropped (no `rvalid`), and any lock is released.
- **Reset priority:** `rst` overrides every input in its cycle. `gnt` stays combinational, but `ram_we` is forced to 0 while `rst` is high.

## Structure
- **Package `ram_arb_pkg`:**
  - state enum `{IDLE, LOCK0, LOCK1}`
  - requester index constants `REQ_CTRL = 0`, `REQ_HOST = 1`
  - tag struct `{valid, id}`
- **Sub-module `rd_tag_pipe`:** parameterised-depth shift register of tags with synchronous active-high clear.
- **Top level:** the arbiter FSM, `prio` register and RAM mux stay in the top module.

## Test plan
- **Single requester reads:** `req = 01`, `addr0 = 0x010` and `0x011` on consecutive cycles, RAM preloaded with `0xA`, `0xB` → `gnt = 01` both cycles; `rvalid = 01` with `rdata = 0xA`, then `0xB`, at T+1 and T+2.
- **Round-robin tie:** `req = 11` for 4 cycles, no lock → `gnt = 01, 10, 01, 10`.
- **Burst lock:** requester 1 asserts `req`+`lock` for 3 cycles while `req[0]` is held → `gnt = 10` ×3. Requester 1 then drops `lock` → next cycle `gnt = 01`.
- **Write then read:** requester 0 writes `0xDEAD` to `0x100` in T, requester 1 reads `0x100` in T+1 → `rvalid = 10`, `rdata = 0xDEAD` at T+2.
- **Reset mid-read:** read granted in T, `rst` high in T+1 → no `rvalid` in any later cycle; `state = IDLE`; the next `req = 11` grants requester 0.
- **Latency parameter:** `RD_LATENCY = 3`, alternating reads from requesters 0 and 1 → `rvalid` pattern `01, 10, …` delayed exactly 3 cycles, data matching the addresses.
